// File: rtl/servant_sleep_ctrl_if.sv
// Sleep/wake controller bus: core-side requests and wake sources in,
// clock-enable, status and wake-cause out.
interface servant_sleep_ctrl_if #(
    parameter int NUM_WAKE = 2,
    parameter int CNT_W    = 8
);
    logic                i_sleep_req;
    logic                i_wakeup_req;
    logic [NUM_WAKE-1:0] i_wake_src;
    logic [NUM_WAKE-1:0] i_wake_mask;
    logic                o_clk_en;
    logic                o_sleeping;
    logic [1:0]          o_state;
    logic [NUM_WAKE:0]   o_wake_cause;
    logic [CNT_W-1:0]    o_sleep_cnt;

    // Core / SoC side: raises requests and wake sources, observes status.
    modport master (
        output i_sleep_req, i_wakeup_req, i_wake_src, i_wake_mask,
        input  o_clk_en, o_sleeping, o_state, o_wake_cause, o_sleep_cnt
    );

    // Controller side.
    modport slave (
        input  i_sleep_req, i_wakeup_req, i_wake_src, i_wake_mask,
        output o_clk_en, o_sleeping, o_state, o_wake_cause, o_sleep_cnt
    );
endinterface

// File: rtl/servant_sleep_ctrl.sv
// Four-state sleep/wake controller for the servant SoC.
// RUN -> DRAIN (programmable delay) -> SLEEP (clock gated) -> WAKE
// (settling delay, still gated) -> RUN. The clock enable is a flop so the
// external ICG sees a clean, edge-aligned enable.
module servant_sleep_ctrl #(
    parameter int NUM_WAKE  = 2,
    parameter int SLEEP_DLY = 4,
    parameter int WAKE_DLY  = 2,
    parameter int CNT_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    servant_sleep_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } state_t;

    // Counter reload values; the counter counts down to zero inclusive,
    // so loading DLY-1 yields exactly DLY cycles of residency.
    localparam logic [7:0] SLEEP_LOAD = (SLEEP_DLY > 0) ? 8'(SLEEP_DLY - 1) : 8'd0;
    localparam logic [7:0] WAKE_LOAD  = (WAKE_DLY  > 0) ? 8'(WAKE_DLY  - 1) : 8'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state, state_nxt;
    logic [7:0]          dly_cnt, dly_cnt_nxt;
    logic                req_prev;
    logic [NUM_WAKE:0]   wake_cause, wake_cause_nxt;
    logic [CNT_W-1:0]    sleep_cnt, sleep_cnt_nxt;
    logic                clk_en;

    logic                sleep_edge;
    logic [NUM_WAKE:0]   wake_vec;
    logic                wake_evt;

    // Event decode: only a fresh rising edge of the sleep request counts;
    // masked wake sources are removed before anything else sees them.
    always_comb begin
        sleep_edge = bus.i_sleep_req & ~req_prev;
        wake_vec   = {bus.i_wake_src & bus.i_wake_mask, bus.i_wakeup_req};
        wake_evt   = |wake_vec;
    end

    // Next-state, delay counter and wake-cause logic.
    always_comb begin
        state_nxt      = state;
        dly_cnt_nxt    = dly_cnt;
        wake_cause_nxt = wake_cause;
        unique case (state)
            RUN: begin
                // A wake already pending when the edge arrives blocks entry.
                if (sleep_edge && !wake_evt) begin
                    wake_cause_nxt = '0;
                    if (SLEEP_DLY == 0) begin
                        state_nxt = SLEEP;
                    end else begin
                        state_nxt   = DRAIN;
                        dly_cnt_nxt = SLEEP_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (wake_evt) begin
                    state_nxt      = RUN;
                    wake_cause_nxt = wake_vec;
                    dly_cnt_nxt    = '0;
                end else if (dly_cnt == 8'd0) begin
                    state_nxt = SLEEP;
                end else begin
                    dly_cnt_nxt = dly_cnt - 8'd1;
                end
            end
            SLEEP: begin
                if (wake_evt) begin
                    wake_cause_nxt = wake_vec;
                    if (WAKE_DLY == 0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt   = WAKE;
                        dly_cnt_nxt = WAKE_LOAD;
                    end
                end
            end
            WAKE: begin
                // Settling window: further wake or sleep events are ignored.
                if (dly_cnt == 8'd0) begin
                    state_nxt = RUN;
                end else begin
                    dly_cnt_nxt = dly_cnt - 8'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Sleep-entry counter bumps on every transition into SLEEP, saturating.
    always_comb begin
        sleep_cnt_nxt = sleep_cnt;
        if (state_nxt == SLEEP && state != SLEEP && sleep_cnt != CNT_MAX)
            sleep_cnt_nxt = sleep_cnt + 1'b1;
    end

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= RUN;
            dly_cnt    <= '0;
            req_prev   <= 1'b0;
            wake_cause <= '0;
            sleep_cnt  <= '0;
            clk_en     <= 1'b1;
        end else begin
            state      <= state_nxt;
            dly_cnt    <= dly_cnt_nxt;
            req_prev   <= bus.i_sleep_req;
            wake_cause <= wake_cause_nxt;
            sleep_cnt  <= sleep_cnt_nxt;
            clk_en     <= (state_nxt == RUN) || (state_nxt == DRAIN);
        end
    end

    // Status outputs come from registers only.
    always_comb begin
        bus.o_clk_en     = clk_en;
        bus.o_state      = state;
        bus.o_sleeping   = (state == SLEEP) || (state == WAKE);
        bus.o_wake_cause = wake_cause;
        bus.o_sleep_cnt  = sleep_cnt;
    end

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// Directed bench for servant_sleep_ctrl: default-parameter instance (a)
// and a zero-delay, 2-bit-counter instance (b).
module tb_servant_sleep_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    servant_sleep_ctrl_if #(.NUM_WAKE(2), .CNT_W(8)) bus_a ();
    servant_sleep_ctrl_if #(.NUM_WAKE(2), .CNT_W(2)) bus_b ();

    servant_sleep_ctrl #(.NUM_WAKE(2), .SLEEP_DLY(4), .WAKE_DLY(2), .CNT_W(8)) dut_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .bus   (bus_a)
    );

    servant_sleep_ctrl #(.NUM_WAKE(2), .SLEEP_DLY(0), .WAKE_DLY(0), .CNT_W(2)) dut_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs changed after this see the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] st, input logic en);
        chk({tag, "_state"}, 32'(bus_a.o_state), 32'(st));
        chk({tag, "_clk_en"}, 32'(bus_a.o_clk_en), 32'(en));
    endtask

    initial begin
        bus_a.i_sleep_req = 0; bus_a.i_wakeup_req = 0;
        bus_a.i_wake_src = 2'b00; bus_a.i_wake_mask = 2'b11;
        bus_b.i_sleep_req = 0; bus_b.i_wakeup_req = 0;
        bus_b.i_wake_src = 2'b00; bus_b.i_wake_mask = 2'b00;
        rst_a = 1; rst_b = 1;
        step();
        step();
        rst_a = 0; rst_b = 0;

        // Reset state
        chk_a("rst", 2'd0, 1'b1);
        chk("rst_sleeping", 32'(bus_a.o_sleeping), 32'd0);
        chk("rst_cause", 32'(bus_a.o_wake_cause), 32'd0);
        chk("rst_cnt", 32'(bus_a.o_sleep_cnt), 32'd0);
        for (int i = 0; i < 8; i++) step();

        // Sleep pulse: 4 DRAIN cycles, then SLEEP with clock gated
        bus_a.i_sleep_req = 1;
        step();
        bus_a.i_sleep_req = 0;
        for (int i = 0; i < 4; i++) begin
            chk_a("drain", 2'd1, 1'b1);
            step();
        end
        chk_a("sleep", 2'd2, 1'b0);
        chk("sleep_sleeping", 32'(bus_a.o_sleeping), 32'd1);
        chk("sleep_cnt1", 32'(bus_a.o_sleep_cnt), 32'd1);

        // Masked source does not wake
        bus_a.i_wake_mask = 2'b10;
        bus_a.i_wake_src  = 2'b01;
        step();
        chk_a("masked", 2'd2, 1'b0);
        step();
        chk_a("masked2", 2'd2, 1'b0);
        bus_a.i_wake_src = 2'b10;
        step();
        bus_a.i_wake_src = 2'b00;
        chk_a("wake1", 2'd3, 1'b0);
        chk("wake1_cause", 32'(bus_a.o_wake_cause), 32'b100);
        chk("wake1_sleeping", 32'(bus_a.o_sleeping), 32'd1);
        step();
        chk_a("wake2", 2'd3, 1'b0);
        step();
        chk_a("run_after_wake", 2'd0, 1'b1);
        chk("run_after_wake_cause", 32'(bus_a.o_wake_cause), 32'b100);
        chk("run_after_wake_sleeping", 32'(bus_a.o_sleeping), 32'd0);
        bus_a.i_wake_mask = 2'b11;
        step();

        // Wake request during 2nd DRAIN cycle aborts the entry
        bus_a.i_sleep_req = 1;
        step();
        bus_a.i_sleep_req = 0;
        chk_a("abort_d1", 2'd1, 1'b1);
        chk("abort_cause_clr", 32'(bus_a.o_wake_cause), 32'd0);
        step();
        chk_a("abort_d2", 2'd1, 1'b1);
        bus_a.i_wakeup_req = 1;
        step();
        bus_a.i_wakeup_req = 0;
        chk_a("abort_run", 2'd0, 1'b1);
        chk("abort_cause", 32'(bus_a.o_wake_cause), 32'b001);
        chk("abort_cnt", 32'(bus_a.o_sleep_cnt), 32'd1);
        step();

        // Held sleep request: exactly one entry
        bus_a.i_sleep_req = 1;
        for (int i = 0; i < 5; i++) step();
        chk_a("held_sleep", 2'd2, 1'b0);
        chk("held_cnt", 32'(bus_a.o_sleep_cnt), 32'd2);
        bus_a.i_wakeup_req = 1;
        step();
        bus_a.i_wakeup_req = 0;
        chk_a("held_wake", 2'd3, 1'b0);
        step();
        step();
        chk_a("held_run", 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk_a("held_no_retrig", 2'd0, 1'b1);
        chk("held_cnt_still", 32'(bus_a.o_sleep_cnt), 32'd2);
        bus_a.i_sleep_req = 0;
        step();
        bus_a.i_sleep_req = 1;
        step();
        chk_a("reraise_drain", 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) step();
        chk_a("reraise_sleep", 2'd2, 1'b0);
        chk("reraise_cnt", 32'(bus_a.o_sleep_cnt), 32'd3);
        bus_a.i_wakeup_req = 1;
        step();
        bus_a.i_wakeup_req = 0;
        chk_a("pre_rst_wake", 2'd3, 1'b0);

        // Reset mid-WAKE
        rst_a = 1;
        bus_a.i_sleep_req = 0;
        step();
        rst_a = 0;
        chk_a("rst_wake", 2'd0, 1'b1);
        chk("rst_wake_cause", 32'(bus_a.o_wake_cause), 32'd0);
        chk("rst_wake_cnt", 32'(bus_a.o_sleep_cnt), 32'd0);
        step();

        // Simultaneous sleep edge and wake request: stay in RUN
        bus_a.i_sleep_req  = 1;
        bus_a.i_wakeup_req = 1;
        step();
        bus_a.i_wakeup_req = 0;
        chk_a("simul", 2'd0, 1'b1);
        chk("simul_cause", 32'(bus_a.o_wake_cause), 32'd0);
        step();
        chk_a("simul_after", 2'd0, 1'b1);
        bus_a.i_sleep_req = 0;

        // Zero-delay instance: five cycles, counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            bus_b.i_sleep_req = 1;
            step();
            bus_b.i_sleep_req = 0;
            chk("b_sleep_state", 32'(bus_b.o_state), 32'd2);
            chk("b_sleep_clk_en", 32'(bus_b.o_clk_en), 32'd0);
            chk("b_sleep_cnt", 32'(bus_b.o_sleep_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
            bus_b.i_wakeup_req = 1;
            step();
            bus_b.i_wakeup_req = 0;
            chk("b_run_state", 32'(bus_b.o_state), 32'd0);
            chk("b_run_clk_en", 32'(bus_b.o_clk_en), 32'd1);
            chk("b_run_cause", 32'(bus_b.o_wake_cause), 32'b001);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/servant_sleep_ctrl.md
Name: servant_sleep_ctrl

Overview:
- Parametrised sleep/wake controller for the servant SoC.
- Replaces the single-bit sleep flop with a four-state controller:
  - programmable drain delay before the core clock is gated;
  - programmable wake-up settling delay;
  - multiple maskable wake sources, with latched wake cause;
  - saturating sleep-entry counter.
- Always clocked by free-running i_clk.
- Drives a registered clock-enable into an external glitch-free ICG that produces wb_clk.

Parameters:
- NUM_WAKE, 2, number of external wake sources (1..16).
- SLEEP_DLY, 4, i_clk cycles spent in DRAIN before gating (0..255; 0 = gate on next cycle).
- WAKE_DLY, 2, i_clk cycles spent in WAKE before ungating (0..255; 0 = ungate on next cycle).
- CNT_W, 8, width of sleep-entry counter (1..32).

Ports:
- i_clk  in  1  free-running clock
- i_rst  in  1  reset, synchronous, active-high
- i_sleep_req  in  1  core sleep request (WFI); level, rising edge acts
- i_wakeup_req  in  1  core/timer wake request; level
- i_wake_src  in  NUM_WAKE  external wake sources; level
- i_wake_mask  in  NUM_WAKE  per-source enable; 1 = enabled
- o_clk_en  out  1  registered enable to ICG; 1 = core clock runs
- o_sleeping  out  1  1 in SLEEP or WAKE
- o_state  out  2  RUN=0, DRAIN=1, SLEEP=2, WAKE=3
- o_wake_cause  out  NUM_WAKE+1  latched cause; bit0 = i_wakeup_req, bit k+1 = i_wake_src[k] & i_wake_mask[k]
- o_sleep_cnt  out  CNT_W  number of SLEEP entries, saturating

Behaviour:
- Definitions:
  - req_prev: registered copy of i_sleep_req, updated every i_clk cycle in every state.
  - sleep_edge = i_sleep_req & ~req_prev.
  - wake_vec = {i_wake_src & i_wake_mask, i_wakeup_req}; wake_evt = |wake_vec.
- Reset values (all registered, effective the cycle after i_rst high):
  - state RUN, o_clk_en 1, o_sleeping 0;
  - o_wake_cause 0, o_sleep_cnt 0, req_prev 0, delay counter 0.
- o_clk_en = 1 in RUN and DRAIN, 0 in SLEEP and WAKE.
  - It is a flop output, changing only on posedge i_clk.
- o_sleeping and o_state are decoded from the state register only; no combinational input-to-output paths.
- RUN:
  - sleep_edge & ~wake_evt → clear o_wake_cause.
    - SLEEP_DLY>0: go to DRAIN, counter = SLEEP_DLY-1.
    - SLEEP_DLY=0: go directly to SLEEP.
  - sleep_edge & wake_evt same cycle → stay RUN; o_wake_cause unchanged.
  - A held-high i_sleep_req never retriggers. Each entry needs a new rising edge.
- DRAIN:
  - wake_evt → RUN (abort); o_wake_cause = wake_vec; o_sleep_cnt unchanged.
  - Otherwise, counter==0 → SLEEP; else decrement.
  - Total DRAIN residency = SLEEP_DLY cycles.
- SLEEP:
  - On entry, o_sleep_cnt += 1, saturating at all-ones.
  - wake_evt → o_wake_cause = wake_vec.
    - WAKE_DLY>0: go to WAKE, counter = WAKE_DLY-1.
    - WAKE_DLY=0: go directly to RUN.
- WAKE:
  - Ignores further wake events and sleep_edge.
  - counter==0 → RUN; else decrement.
  - Total WAKE residency = WAKE_DLY cycles.
- Wake sources are level-sensitive. Masked sources (mask bit 0) never wake the core and never appear in o_wake_cause.
- A wake source already asserted when the sleep edge arrives blocks entry (RUN rule above).
- i_rst in any state, including mid-DRAIN or mid-WAKE, returns to RUN with o_clk_en=1 on the next cycle. Counter and cause are cleared.
- Delay counter width is 8 bits. o_sleep_cnt width is CNT_W.

Test Plan:
- Defaults. Reset, then pulse i_sleep_req at cycle 10 → o_state=DRAIN cycles 11-14, SLEEP at 15, o_clk_en=0 at 15, o_sleep_cnt=1.
- From SLEEP, mask=2'b10, pulse i_wake_src=2'b01 → no wake. Then raise i_wake_src[1] → WAKE for 2 cycles, then RUN with o_clk_en=1 and o_wake_cause=3'b100.
- i_wakeup_req asserted during the 2nd DRAIN cycle → RUN next cycle, o_clk_en never drops, o_wake_cause=3'b001, o_sleep_cnt unchanged.
- i_sleep_req held high across a full sleep/wake cycle → exactly one SLEEP entry (o_sleep_cnt increments by 1 only). Drop and re-raise → second entry.
- SLEEP_DLY=0, WAKE_DLY=0, CNT_W=2. Five sleep/wake cycles → SLEEP is entered the cycle after the edge; RUN the cycle after wake; o_sleep_cnt saturates at 3.
- i_rst asserted for 1 cycle while in WAKE → RUN, o_clk_en=1, o_wake_cause=0, o_sleep_cnt=0 the next cycle. Simultaneous sleep_edge and i_wakeup_req in RUN → state stays RUN.
